fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 65 ++++++
 rtl/fetch_queue.sv | 116 +++++++++++
 tb/tb_fetch_queue.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared RV32I defaults for the fetch front end: reset PC, NOP encoding, data width
// and the fetch sequencer state codes.
package fetch_queue_pkg;

  localparam int unsigned XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSN         = 32'h0000_0013;

  localparam logic [1:0] ST_RUN        = 2'd0;
  localparam logic [1:0] ST_FAULT_PUSH = 2'd1;
  localparam logic [1:0] ST_HALT       = 2'd2;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous DEPTH x WIDTH FIFO with flush, combinational head read and occupancy count.
// Push and pop are individually guarded so the queue can never overflow or underflow.
module fetch_fifo
  import fetch_queue_pkg::*;
#(
  parameter int unsigned WIDTH = 65,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  always_comb begin
    pop_ok   = pop && (count_q != '0);
    // a full queue still accepts a push when the head leaves in the same cycle
    push_ok  = push && ((count_q != CW'(DEPTH)) || pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !flush && push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: sequential PC fetch into a small FIFO with redirect/flush.
// Define FETCH_QUEUE_MISALIGN_CHECK_EN to fault misaligned redirect targets instead of aligning them.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned      XLEN     = XLEN_DEFAULT,
  parameter int unsigned      DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_redirect,
  input  logic [XLEN-1:0]          i_redirect_PC,
  output logic                     o_imem_req,
  output logic [XLEN-1:0]          o_imem_addr,
  input  logic [XLEN-1:0]          i_imem_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [XLEN-1:0]          o_PC,
  output logic [XLEN-1:0]          o_Instruction,
  output logic                     o_fault,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned EW = 2 * XLEN + 1;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic            inflight_q, inflight_d;
  logic [1:0]      state_q, state_d;

  logic [CW-1:0]   count;
  logic [EW-1:0]   head_data, push_data;
  logic            push, pop, req;
  logic [XLEN-1:0] target;
  logic            target_fault;

`ifdef FETCH_QUEUE_MISALIGN_CHECK_EN
  assign target       = i_redirect_PC;
  assign target_fault = (i_redirect_PC[1:0] != 2'b00);
`else
  assign target       = i_redirect_PC & ~XLEN'(3);
  assign target_fault = 1'b0;
`endif

  always_comb begin
    req = 1'b0;
    if (!reset && !i_redirect && (state_q == ST_RUN))
      req = (count + CW'(inflight_q)) < CW'(DEPTH);

    push      = 1'b0;
    push_data = {req_addr_q, i_imem_data, 1'b0};
    if (state_q == ST_FAULT_PUSH) begin
      push      = 1'b1;
      push_data = {fetch_pc_q, XLEN'(NOP_INSN), 1'b1};
    end else if (inflight_q) begin
      push = 1'b1;
    end
    pop = o_valid && i_ready;

    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    state_d    = state_q;
    inflight_d = req;
    if (req) begin
      req_addr_d = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + XLEN'(4);
    end
    // a redirect cancels any response landing this cycle via the FIFO flush
    if (i_redirect) begin
      fetch_pc_d = target;
      state_d    = target_fault ? ST_FAULT_PUSH : ST_RUN;
    end else if (state_q == ST_FAULT_PUSH) begin
      state_d = ST_HALT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      req_addr_q <= '0;
      inflight_q <= 1'b0;
      state_q    <= ST_RUN;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      inflight_q <= inflight_d;
      state_q    <= state_d;
    end
  end

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (i_redirect),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head_data (head_data),
    .count     (count)
  );

  // Outputs read zero while in reset or while the queue is empty.
  assign o_imem_req    = req;
  assign o_imem_addr   = fetch_pc_q;
  assign o_valid       = !reset && (count != '0);
  assign o_count       = reset ? '0 : count;
  assign o_PC          = o_valid ? head_data[EW-1 -: XLEN] : '0;
  assign o_Instruction = o_valid ? head_data[XLEN:1] : '0;
  assign o_fault       = o_valid && head_data[0];

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized and directed bench for fetch_queue against a queue-based reference model.
module tb_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef FETCH_QUEUE_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, i_redirect, i_ready;
  logic [31:0] i_redirect_PC, i_imem_data, o_imem_addr, o_PC, o_Instruction;
  logic        o_imem_req, o_valid, o_fault;
  logic [2:0]  o_count;

  fetch_queue dut (
    .clk           (clk),
    .reset         (reset),
    .i_redirect    (i_redirect),
    .i_redirect_PC (i_redirect_PC),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_data   (i_imem_data),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_PC          (o_PC),
    .o_Instruction (o_Instruction),
    .o_fault       (o_fault),
    .o_count       (o_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  // Memory answers one cycle after a request; garbage otherwise.
  always @(posedge clk) i_imem_data <= o_imem_req ? memf(o_imem_addr) : $urandom();

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic        f;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc, m_iaddr;
  bit          m_infl, m_pend, m_halt;

  int total, bad;
  logic [31:0] req_log[$], pop_log[$];
  logic        obs_req, obs_valid, obs_fault;
  logic [31:0] obs_addr, obs_pc, obs_insn;
  logic [2:0]  obs_count;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic rst, input logic redir, input logic [31:0] tgt, input logic rdy);
    logic e_req, e_valid;
    logic [2:0] e_count;
    ent_t h;
    reset = rst; i_redirect = redir; i_redirect_PC = tgt; i_ready = rdy;
    @(negedge clk);
    obs_req = o_imem_req; obs_addr = o_imem_addr; obs_valid = o_valid;
    obs_count = o_count; obs_pc = o_PC; obs_insn = o_Instruction; obs_fault = o_fault;
    e_valid = !rst && (mq.size() != 0);
    e_req   = !rst && !redir && !m_pend && !m_halt && (mq.size() + (m_infl ? 1 : 0) < DEPTH);
    e_count = rst ? 3'd0 : 3'(mq.size());
    h = '0;
    if (e_valid) h = mq[0];
    chk("req", obs_req, e_req);
    if (e_req) chk("addr", obs_addr, m_pc);
    chk("valid", obs_valid, e_valid);
    chk("count", obs_count, e_count);
    chk("pc", obs_pc, h.pc);
    chk("insn", obs_insn, h.insn);
    chk("fault", obs_fault, h.f);
    if (obs_req === 1'b1 && !rst) req_log.push_back(obs_addr);
    if (obs_valid === 1'b1 && rdy && !redir && !rst) pop_log.push_back(obs_pc);
    if (rst) begin
      mq.delete(); m_pc = RESET_PC; m_infl = 0; m_pend = 0; m_halt = 0;
    end else if (redir) begin
      mq.delete(); m_infl = 0;
      if (MIS_EN && tgt[1:0] != 2'b00) begin
        m_pc = tgt; m_pend = 1; m_halt = 1;
      end else begin
        m_pc = {tgt[31:2], 2'b00}; m_pend = 0; m_halt = 0;
      end
    end else begin
      if (e_valid && rdy) void'(mq.pop_front());
      if (m_infl) mq.push_back(ent_t'({m_iaddr, memf(m_iaddr), 1'b0}));
      if (m_pend) begin
        mq.push_back(ent_t'({m_pc, NOP, 1'b1}));
        m_pend = 0;
      end
      if (e_req) begin
        m_infl = 1; m_iaddr = m_pc; m_pc = m_pc + 32'd4;
      end else begin
        m_infl = 0;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int first_req, first_valid;
    total = 0; bad = 0;
    reset = 1'b1; i_redirect = 1'b0; i_redirect_PC = '0; i_ready = 1'b0;
    m_pc = RESET_PC; m_iaddr = '0; m_infl = 0; m_pend = 0; m_halt = 0;
    @(posedge clk); #1;

    // Reset state, then sequential fetch from RESET_PC
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 1);
    req_log.delete(); pop_log.delete();
    first_req = -1; first_valid = -1;
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 0, 1);
      if (first_req < 0 && obs_req === 1'b1) first_req = i;
      if (first_valid < 0 && obs_valid === 1'b1) first_valid = i;
    end
    chk("first_req_cycle", first_req, 0);
    chk("issue_to_valid", first_valid - first_req, 2);
    chk("req_addr0", req_log[0], 32'h0);
    chk("req_addr1", req_log[1], 32'h4);
    chk("req_addr2", req_log[2], 32'h8);
    chk("pop_pc0", pop_log[0], 32'h0);
    chk("pop_pc1", pop_log[1], 32'h4);
    chk("pop_pc2", pop_log[2], 32'h8);

    // Back-pressure: exactly DEPTH requests, then resume at 0x10
    for (int i = 0; i < 2; i++) cycle(1, 0, 0, 0);
    req_log.delete();
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0);
    chk("stall_req_total", req_log.size(), 4);
    chk("stall_req_low", obs_req, 1'b0);
    chk("stall_count", obs_count, 3'd4);
    req_log.delete();
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1);
    chk("resume_addr", req_log[0], 32'h10);

    // Redirect with 3 queued and one in flight
    for (int i = 0; i < 2; i++) cycle(1, 0, 0, 0);
    for (int i = 0; i < 10 && !(mq.size() == 3 && m_infl); i++) cycle(0, 0, 0, 0);
    cycle(0, 1, 32'h100, 0);
    chk("redir_pre_count", obs_count, 3'd3);
    pop_log.delete();
    cycle(0, 0, 0, 1);
    chk("redir_next_count", obs_count, 3'd0);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1);
    chk("redir_first_pc", pop_log[0], 32'h100);
    chk("redir_second_pc", pop_log[1], 32'h104);

    // Redirect and handshake in the same cycle
    cycle(0, 1, 32'h200, 1);
    chk("hs_valid_at_redirect", obs_valid, 1'b1);
    cycle(0, 0, 0, 0);
    chk("hs_count", obs_count, 3'd0);
    chk("hs_req", obs_req, 1'b1);
    chk("hs_addr", obs_addr, 32'h200);

    // Fetch PC wraps modulo 2^32
    req_log.delete();
    cycle(0, 1, 32'hFFFF_FFF8, 1);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1);
    chk("wrap_addr0", req_log[0], 32'hFFFF_FFF8);
    chk("wrap_addr1", req_log[1], 32'hFFFF_FFFC);
    chk("wrap_addr2", req_log[2], 32'h0);
    chk("wrap_addr3", req_log[3], 32'h4);

    // Misaligned redirect target
    cycle(0, 1, 32'h102, 0);
    req_log.delete();
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0);
`ifdef FETCH_QUEUE_MISALIGN_CHECK_EN
    chk("mis_no_req", req_log.size(), 0);
    chk("mis_count", obs_count, 3'd1);
    chk("mis_pc", obs_pc, 32'h102);
    chk("mis_fault", obs_fault, 1'b1);
    chk("mis_insn", obs_insn, NOP);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1);
    chk("mis_halt_no_req", req_log.size(), 0);
    chk("mis_drained", obs_count, 3'd0);
`else
    chk("align_reqs", req_log.size(), 4);
    chk("align_pc", obs_pc, 32'h100);
    chk("align_fault", obs_fault, 1'b0);
    chk("align_count", obs_count, 3'd4);
`endif
    req_log.delete();
    cycle(0, 1, 32'h300, 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1);
    chk("after_mis_addr", req_log[0], 32'h300);

    // Reset mid-stream
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1);
    cycle(1, 0, 0, 1);
    chk("midrst_req", obs_req, 1'b0);
    chk("midrst_valid", obs_valid, 1'b0);
    cycle(1, 0, 0, 1);
    chk("midrst_next_count", obs_count, 3'd0);
    chk("midrst_next_pc", obs_pc, 32'h0);
    req_log.delete();
    cycle(0, 0, 0, 1);
    chk("midrst_restart", req_log[0], RESET_PC);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      int r;
      logic [31:0] tgt;
      r = $urandom_range(0, 99);
      tgt = $urandom();
      if (r == 7) tgt = 32'hFFFF_FFF8;
      cycle(r < 2, (r >= 2 && r < 8), tgt, $urandom_range(0, 3) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
